// File: rtl/oven_countdown.sv
// oven_countdown
// Consumer end of the oven front-panel entry path. Takes a 4-digit BCD cook
// time (MM:SS) from the panel entry block and counts it down once per
// TICK_DIV clock cycles. It drives the heater enable, the finished flag,
// the buzzer, and the four remaining-time digits for the 7-segment decoders.
//
// Ports:
//   clk        system clock
//   onOff      asynchronous active-low reset, doubles as the oven power switch
//   btn[1:0]   active-low buttons, asynchronous to clk: [0] start/pause, [1] cancel
//   load_valid time_in is valid this cycle
//   load_ready block accepts a load this cycle (IDLE or DONE)
//   time_in    BCD digits {tens of min, min, tens of sec, sec}
//   hex0..hex3 remaining time: seconds units, seconds tens, minutes units, minutes tens
//   heat_on    heater enable
//   done       countdown finished
//   alarm      buzzer drive, held for ALARM_SECS seconds after reaching 00:00
module oven_countdown #(
  parameter int TICK_DIV   = 50000000,
  parameter int ALARM_SECS = 3
) (
  input  logic        clk,
  input  logic        onOff,
  input  logic [1:0]  btn,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] time_in,
  output logic [3:0]  hex0,
  output logic [3:0]  hex1,
  output logic [3:0]  hex2,
  output logic [3:0]  hex3,
  output logic        heat_on,
  output logic        done,
  output logic        alarm
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int AW = $clog2(ALARM_SECS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SECS - 1);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    RUNNING,
    PAUSED,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [AW-1:0] alarmCnt_q, alarmCnt_d;
  logic [15:0]   digits_q, digits_d;
  logic          heat_q, heat_d;
  logic          done_q, done_d;
  logic          alarm_q, alarm_d;
  logic          ready_q, ready_d;

  logic [1:0]    btnMeta_q, btnSync_q, btnPrev_q;
  logic          startP, cancelP, tick;
  logic [15:0]   decDigits, loadDigits;

  // Clamp each digit to 9, then the tens-of-seconds digit to 5.
  function automatic logic [15:0] sanitize(input logic [15:0] t);
    logic [3:0] d0, d1, d2, d3;
    d0 = (t[3:0]   > 4'd9) ? 4'd9 : t[3:0];
    d1 = (t[7:4]   > 4'd9) ? 4'd9 : t[7:4];
    d2 = (t[11:8]  > 4'd9) ? 4'd9 : t[11:8];
    d3 = (t[15:12] > 4'd9) ? 4'd9 : t[15:12];
    if (d1 > 4'd5) d1 = 4'd5;
    return {d3, d2, d1, d0};
  endfunction

  // MM:SS decrement with borrow; seconds tens wraps to 5, the rest to 9.
  // Never called with 00:00, because RUNNING is only entered with a nonzero time.
  function automatic logic [15:0] bcdDec(input logic [15:0] t);
    logic [3:0] d0, d1, d2, d3;
    {d3, d2, d1, d0} = t;
    if (d0 != 4'd0) begin
      d0 = d0 - 4'd1;
    end else begin
      d0 = 4'd9;
      if (d1 != 4'd0) begin
        d1 = d1 - 4'd1;
      end else begin
        d1 = 4'd5;
        if (d2 != 4'd0) begin
          d2 = d2 - 4'd1;
        end else begin
          d2 = 4'd9;
          d3 = d3 - 4'd1;
        end
      end
    end
    return {d3, d2, d1, d0};
  endfunction

  // A press is a falling edge of the synchronised level. The synchronisers
  // reset to 0, so a released (high) button after reset never looks like a press.
  assign startP     = btnPrev_q[0] & ~btnSync_q[0];
  assign cancelP    = btnPrev_q[1] & ~btnSync_q[1];
  assign tick       = (presc_q == PRESC_LAST);
  assign decDigits  = bcdDec(digits_q);
  assign loadDigits = sanitize(time_in);

  always_ff @(posedge clk or negedge onOff) begin
    if (!onOff) begin
      btnMeta_q <= 2'b00;
      btnSync_q <= 2'b00;
      btnPrev_q <= 2'b00;
    end else begin
      btnMeta_q <= btn;
      btnSync_q <= btnMeta_q;
      btnPrev_q <= btnSync_q;
    end
  end

  // Cancel is checked first, so it wins over start and load in the same cycle.
  // Inside RUNNING, a pause press wins over a tick: the prescaler then holds at
  // its last value and ticks on the first cycle after resume.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    alarmCnt_d = alarmCnt_q;
    digits_d   = digits_q;
    heat_d     = heat_q;
    done_d     = done_q;
    alarm_d    = alarm_q;

    if (cancelP) begin
      state_d    = IDLE;
      presc_d    = '0;
      alarmCnt_d = '0;
      digits_d   = 16'h0000;
      heat_d     = 1'b0;
      done_d     = 1'b0;
      alarm_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_valid) begin
            state_d  = ARMED;
            digits_d = loadDigits;
            done_d   = 1'b0;
            alarm_d  = 1'b0;
          end
        end
        ARMED: begin
          if (startP && (digits_q != 16'h0000)) begin
            state_d = RUNNING;
            presc_d = '0;
            heat_d  = 1'b1;
          end
        end
        RUNNING: begin
          if (startP) begin
            state_d = PAUSED;
            heat_d  = 1'b0;
          end else if (tick) begin
            presc_d  = '0;
            digits_d = decDigits;
            if (decDigits == 16'h0000) begin
              state_d    = DONE;
              heat_d     = 1'b0;
              done_d     = 1'b1;
              alarm_d    = 1'b1;
              alarmCnt_d = '0;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        PAUSED: begin
          if (startP) begin
            state_d = RUNNING;
            heat_d  = 1'b1;
          end
        end
        DONE: begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick && alarm_q) begin
            if (alarmCnt_q == ALARM_LAST) begin
              alarm_d = 1'b0;
            end else begin
              alarmCnt_d = alarmCnt_q + AW'(1);
            end
          end
          if (load_valid) begin
            state_d  = ARMED;
            digits_d = loadDigits;
            done_d   = 1'b0;
            alarm_d  = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    ready_d = (state_d == IDLE) || (state_d == DONE);
  end

  always_ff @(posedge clk or negedge onOff) begin
    if (!onOff) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      alarmCnt_q <= '0;
      digits_q   <= 16'h0000;
      heat_q     <= 1'b0;
      done_q     <= 1'b0;
      alarm_q    <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      alarmCnt_q <= alarmCnt_d;
      digits_q   <= digits_d;
      heat_q     <= heat_d;
      done_q     <= done_d;
      alarm_q    <= alarm_d;
      ready_q    <= ready_d;
    end
  end

  assign {hex3, hex2, hex1, hex0} = digits_q;
  assign heat_on    = heat_q;
  assign done       = done_q;
  assign alarm      = alarm_q;
  assign load_ready = ready_q;

endmodule

// File: tb/tb_oven_countdown.sv
// Testbench for oven_countdown, built with TICK_DIV=4 and ALARM_SECS=2.
// Load vectors come from a table, and multi-cycle behaviour uses hand-written sequences.
module tb_oven_countdown;

   logic        clk;
   logic        onOff;
   logic [1:0]  btn;
   logic        load_valid;
   logic        load_ready;
   logic [15:0] time_in;
   logic [3:0]  hex0, hex1, hex2, hex3;
   logic        heat_on, done, alarm;
   logic [15:0] hexAll;

   int compared = 0;
   int mismatched = 0;

   typedef struct {
      logic [15:0] timeIn;
      logic [15:0] expHex;
   } loadVec_t;

   loadVec_t vecs[6];

   oven_countdown #(
      .TICK_DIV(4),
      .ALARM_SECS(2)
   ) dut (
      .clk(clk),
      .onOff(onOff),
      .btn(btn),
      .load_valid(load_valid),
      .load_ready(load_ready),
      .time_in(time_in),
      .hex0(hex0),
      .hex1(hex1),
      .hex2(hex2),
      .hex3(hex3),
      .heat_on(heat_on),
      .done(done),
      .alarm(alarm)
   );

   assign hexAll = {hex3, hex2, hex1, hex0};

   // 10-unit clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge, then settle 1 unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // A press acts on the third edge after driving the button. The task
   // returns just after that edge and releases the button.
   task automatic pressBtn(input int idx);
      btn[idx] = 1'b0;
      repeat (3) step();
      btn[idx] = 1'b1;
   endtask

   task automatic doCancel();
      pressBtn(1);
      repeat (3) step();
   endtask

   task automatic loadTime(input logic [15:0] t);
      load_valid = 1'b1;
      time_in = t;
      step();
      load_valid = 1'b0;
      time_in = 16'h0000;
   endtask

   // Cancel to IDLE, then load one table entry and check the sanitised digits.
   task automatic applyStimulus(input loadVec_t v);
      doCancel();
      checkOutput("idle hex", hexAll, 16'h0000);
      checkOutput("idle ready", {15'd0, load_ready}, 16'd1);
      loadTime(v.timeIn);
      checkOutput($sformatf("load %h hex", v.timeIn), hexAll, v.expHex);
      checkOutput("armed ready", {15'd0, load_ready}, 16'd0);
      checkOutput("armed heat", {15'd0, heat_on}, 16'd0);
   endtask

   function automatic logic [15:0] toBcd(input int s);
      int m, sec;
      m = s / 60;
      sec = s % 60;
      return {4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
   endfunction

   initial begin
      vecs[0] = '{16'h0012, 16'h0012};
      vecs[1] = '{16'hAB7C, 16'h9959};
      vecs[2] = '{16'h0100, 16'h0100};
      vecs[3] = '{16'h5959, 16'h5959};
      vecs[4] = '{16'h0F60, 16'h0950};
      vecs[5] = '{16'h9999, 16'h9959};

      onOff = 1'b0;
      btn = 2'b11;
      load_valid = 1'b0;
      time_in = 16'h0000;

      // Reset state
      repeat (3) step();
      checkOutput("reset hex", hexAll, 16'h0000);
      checkOutput("reset flags", {13'd0, heat_on, done, alarm}, 16'd0);
      checkOutput("reset ready", {15'd0, load_ready}, 16'd1);
      @(negedge clk);
      onOff = 1'b1;
      repeat (4) step();

      // Load table, including digit clamping
      for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

      // Countdown 01:00 -> 00:00 with the borrow chain, then alarm and DONE
      doCancel();
      loadTime(16'h0100);
      pressBtn(0);
      checkOutput("run heat", {15'd0, heat_on}, 16'd1);
      repeat (3) step();
      checkOutput("pre-tick hex", hexAll, 16'h0100);
      step();
      checkOutput("first tick hex", hexAll, 16'h0059);
      for (int s = 58; s >= 0; s--) begin
         repeat (4) step();
         checkOutput($sformatf("countdown %0d", s), hexAll, toBcd(s));
      end
      checkOutput("done flags", {13'd0, heat_on, done, alarm}, 16'b011);
      checkOutput("done ready", {15'd0, load_ready}, 16'd1);
      repeat (7) step();
      checkOutput("alarm held", {15'd0, alarm}, 16'd1);
      step();
      checkOutput("alarm off", {15'd0, alarm}, 16'd0);
      checkOutput("done held", {15'd0, done}, 16'd1);
      repeat (2) step();
      pressBtn(0);
      checkOutput("start in DONE ignored", {12'd0, heat_on, done, alarm, 1'b0}, 16'b0100);
      checkOutput("DONE hex", hexAll, 16'h0000);

      // Pause and resume
      repeat (3) step();
      loadTime(16'h0005);
      checkOutput("reload clears done", {15'd0, done}, 16'd0);
      pressBtn(0);
      repeat (4) step();
      checkOutput("pause pre hex", hexAll, 16'h0004);
      pressBtn(0);
      checkOutput("paused heat", {15'd0, heat_on}, 16'd0);
      repeat (20) step();
      checkOutput("paused frozen", hexAll, 16'h0004);
      checkOutput("paused heat held", {15'd0, heat_on}, 16'd0);
      pressBtn(0);
      checkOutput("resumed heat", {15'd0, heat_on}, 16'd1);
      step();
      checkOutput("resume +1", hexAll, 16'h0004);
      step();
      checkOutput("resume +2", hexAll, 16'h0003);

      // Pause lands on the tick cycle: no decrement, tick right after resume
      step();
      pressBtn(0);
      checkOutput("pause beats tick", hexAll, 16'h0003);
      repeat (3) step();
      pressBtn(0);
      checkOutput("resume held presc", hexAll, 16'h0003);
      step();
      checkOutput("tick after resume", hexAll, 16'h0002);

      // Zero load cannot start
      doCancel();
      loadTime(16'h0000);
      pressBtn(0);
      repeat (6) step();
      checkOutput("zero start heat", {15'd0, heat_on}, 16'd0);
      checkOutput("zero start ready", {15'd0, load_ready}, 16'd0);

      // Cancel beats start in RUNNING
      doCancel();
      loadTime(16'h0030);
      pressBtn(0);
      repeat (3) step();
      btn = 2'b00;
      repeat (3) step();
      btn = 2'b11;
      checkOutput("cancel+start hex", hexAll, 16'h0000);
      checkOutput("cancel+start flags", {14'd0, heat_on, load_ready}, 16'b01);
      repeat (3) step();

      // Held start gives one press only
      loadTime(16'h0030);
      btn[0] = 1'b0;
      repeat (3) step();
      checkOutput("held start runs", {15'd0, heat_on}, 16'd1);
      repeat (47) step();
      checkOutput("held no toggle", {15'd0, heat_on}, 16'd1);
      checkOutput("held hex", hexAll, 16'h0019);
      btn[0] = 1'b1;
      repeat (3) step();

      // Load while RUNNING is ignored
      loadTime(16'h1234);
      checkOutput("load ignored hex", hexAll, 16'h0018);
      checkOutput("load ignored ready", {15'd0, load_ready}, 16'd0);

      // Asynchronous reset between clock edges
      #3;
      onOff = 1'b0;
      #1;
      checkOutput("async rst hex", hexAll, 16'h0000);
      checkOutput("async rst flags", {13'd0, heat_on, done, alarm}, 16'd0);
      checkOutput("async rst ready", {15'd0, load_ready}, 16'd1);
      repeat (2) step();
      @(negedge clk);
      onOff = 1'b1;
      repeat (6) step();
      checkOutput("post rst hex", hexAll, 16'h0000);
      checkOutput("post rst heat", {15'd0, heat_on}, 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/oven_countdown.md
Name: oven_countdown

Overview:
- Consumer end of the oven front-panel entry path: accepts a 4-digit BCD cook time (MM:SS) captured by the panel input logic, then counts it down at 1 Hz.
- Drives the heater-enable and alarm outputs and the four remaining-time display digits.
- Start/pause and cancel come from the active-low push buttons.
- Sits between the panel entry block and the 7-segment decoders.

Parameters:
- TICK_DIV, 50000000, clk cycles per countdown second; minimum 2.
- ALARM_SECS, 3, seconds alarm stays high after reaching 00:00; minimum 1.

Ports:
- clk  in  1  system clock
- onOff  in  1  asynchronous active-low reset; also the oven power switch
- btn  in  2  active-low buttons, asynchronous to clk: [0] start/pause, [1] cancel
- load_valid  in  1  time_in is valid this cycle
- load_ready  out  1  block accepts a load this cycle
- time_in  in  16  BCD digits: [15:12] tens of minutes, [11:8] minutes, [7:4] tens of seconds, [3:0] seconds
- hex0  out  4  remaining seconds, units
- hex1  out  4  remaining seconds, tens
- hex2  out  4  remaining minutes, units
- hex3  out  4  remaining minutes, tens
- heat_on  out  1  heater enable
- done  out  1  countdown finished
- alarm  out  1  buzzer drive

Behaviour:
- Reset (onOff=0, asynchronous):
  - State IDLE; all hex = 0; heat_on, done and alarm = 0.
  - Prescaler, alarm counter and button synchronisers cleared.
- Button conditioning:
  - Each btn bit passes through a 2-FF synchroniser.
  - A press is a 1→0 transition of the synchronised value, producing a 1-cycle pulse: start_p or cancel_p.
  - A held button produces only one pulse.
- States: IDLE, ARMED, RUNNING, PAUSED, DONE.
- load_ready = 1 in IDLE or DONE, else 0.
- Load handshake (load_valid & load_ready):
  - Digits are registered into hex3..hex0 next cycle; done and alarm clear; state becomes ARMED.
  - Digit sanitisation: any digit >9 is clamped to 9, then hex1 >5 is clamped to 5.
  - load_valid while load_ready=0 is ignored; no state change.
- ARMED:
  - start_p with a nonzero time → RUNNING; prescaler set to 0; heat_on=1 from the following cycle.
  - start_p with time 00:00 → ignored.
- RUNNING:
  - Prescaler counts 0..TICK_DIV-1; a tick occurs on the cycle it wraps.
  - First decrement is exactly TICK_DIV cycles after entering RUNNING.
  - Tick performs a BCD decrement with borrow:
    - hex0 9→0 then borrow (hex0→9);
    - hex1 5→0 then borrow (hex1→5);
    - hex2 9→0 then borrow (hex2→9);
    - hex3 decrements.
  - When the decrement yields 00:00: same edge → DONE, heat_on=0, done=1, alarm=1.
  - start_p → PAUSED: heat_on=0; prescaler and digits frozen.
- PAUSED:
  - start_p → RUNNING; prescaler resumes from its held value, not restarted.
- DONE:
  - alarm stays high for ALARM_SECS ticks (prescaler keeps running), then 0.
  - done stays 1 until a new load or cancel.
  - hex digits stay 0.
  - start_p is ignored.
- cancel_p, any state: → IDLE; hex = 0; heat_on, done and alarm = 0; prescaler = 0.
- Simultaneous events:
  - cancel_p beats start_p and load.
  - start_p (pause) beats a tick in the same cycle: no decrement, prescaler holds at TICK_DIV-1 and ticks on the first cycle after resume.
- Mid-operation reset: onOff low in any state forces full reset immediately; no decrement or alarm completes.
- All outputs are registered.

Test Plan (TICK_DIV=4, ALARM_SECS=2):
- Reset and load: reset; load 0x0012 → load_ready=0 next cycle; hex3..0=0,0,1,2; state ARMED; heat_on=0.
- Countdown with borrow chain: load 0x0100, press btn[0] → 4 cycles later hex=00:59, then 00:58 every 4 cycles; at 00:00 done=1, heat_on=0, alarm=1 for 8 cycles then 0, done stays 1.
- Pause and resume: load 0x0005, start, pause after 6 cycles → hex=00:04 frozen for 20 cycles with heat_on=0; resume → 00:03 after 2 cycles.
- Clamping and zero load: load 0xAB7C → hex=9,9,5,9; load 0x0000 then press start → remains ARMED, heat_on=0.
- Cancel beats start: cancel and start pressed together in RUNNING → IDLE, all hex 0. Held btn[0] for 50 cycles → single toggle only.
- Async reset: onOff low mid-RUNNING between clk edges → outputs 0 immediately; load_valid while RUNNING ignored (hex unchanged).
